// File: rtl/pixel_result_collector.sv
// Runs one pixel job at a time on a pixelpointprocessor and writes each result
// to the output feature-map memory at consecutive addresses.
module pixel_result_collector #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int OUT_AW  = 12,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] stride_a,
  input  logic [CNT_W-1:0]  num_pix,
  input  logic [OUT_AW-1:0] out_base,
  output logic              busy,
  output logic              finished,
  output logic              timeout_err,
  output logic              pp_en,
  output logic [ADDR_W-1:0] pp_base_addrA,
  output logic [ADDR_W-1:0] pp_base_addrB,
  input  logic [DATA_W-1:0] pp_out_pix,
  input  logic              pp_done,
  output logic              pp_ack,
  output logic              wr_en,
  output logic [OUT_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  // Watchdog counts 0..TIMEOUT-1 REQ cycles; hitting the last value aborts the job.
  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam bit              WD_ON   = (TIMEOUT > 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_FIN} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  num_pix_q, num_pix_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              busy_d, finished_d, timeout_err_d, pp_en_d, pp_ack_d, wr_en_d;
  logic [ADDR_W-1:0] addr_a_d, addr_b_d;
  logic [OUT_AW-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      stride_q      <= '0;
      num_pix_q     <= '0;
      cnt_q         <= '0;
      wd_q          <= '0;
      busy          <= 1'b0;
      finished      <= 1'b0;
      timeout_err   <= 1'b0;
      pp_en         <= 1'b0;
      pp_ack        <= 1'b0;
      wr_en         <= 1'b0;
      pp_base_addrA <= '0;
      pp_base_addrB <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      state_q       <= state_d;
      stride_q      <= stride_d;
      num_pix_q     <= num_pix_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      busy          <= busy_d;
      finished      <= finished_d;
      timeout_err   <= timeout_err_d;
      pp_en         <= pp_en_d;
      pp_ack        <= pp_ack_d;
      wr_en         <= wr_en_d;
      pp_base_addrA <= addr_a_d;
      pp_base_addrB <= addr_b_d;
      wr_addr       <= wr_addr_d;
      wr_data       <= wr_data_d;
    end
  end

  // Processor handshake: pp_en requests a pixel, pp_done marks the result valid,
  // pp_ack holds until pp_done falls (4-phase), after which the next request may start.
  always_comb begin
    state_d       = state_q;
    stride_d      = stride_q;
    num_pix_d     = num_pix_q;
    cnt_d         = cnt_q;
    wd_d          = wd_q;
    busy_d        = busy;
    finished_d    = 1'b0;
    timeout_err_d = timeout_err;
    pp_en_d       = pp_en;
    pp_ack_d      = pp_ack;
    wr_en_d       = 1'b0;
    addr_a_d      = pp_base_addrA;
    addr_b_d      = pp_base_addrB;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stride_d      = stride_a;
          num_pix_d     = num_pix;
          cnt_d         = '0;
          wd_d          = '0;
          busy_d        = 1'b1;
          timeout_err_d = 1'b0;
          addr_a_d      = base_a;
          addr_b_d      = base_b;
          wr_addr_d     = out_base;
          if (num_pix == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_REQ;
            pp_en_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (pp_done) begin
          wr_data_d = pp_out_pix;
          wr_en_d   = 1'b1;
          pp_en_d   = 1'b0;
          pp_ack_d  = 1'b1;
          state_d   = S_ACK;
        end else if (WD_ON && wd_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          pp_en_d       = 1'b0;
          state_d       = S_FIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_ACK: begin
        if (!pp_done) begin
          pp_ack_d  = 1'b0;
          cnt_d     = cnt_q + 1'b1;
          addr_a_d  = pp_base_addrA + stride_q;
          wr_addr_d = wr_addr + 1'b1;
          wd_d      = '0;
          if (cnt_d == num_pix_q) begin
            state_d = S_FIN;
          end else begin
            state_d = S_REQ;
            pp_en_d = 1'b1;
          end
        end
      end
      S_FIN: begin
        finished_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_result_collector.sv
// Directed and randomized checks of pixel_result_collector against a responder
// model of the pixel processor and an address/data reference model.
module tb_pixel_result_collector;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int OUT_AW = 12;
  localparam int CNT_W  = 12;
  localparam int TO     = 20;

  logic              clk, rst_n, start;
  logic [ADDR_W-1:0] base_a, base_b, stride_a;
  logic [CNT_W-1:0]  num_pix;
  logic [OUT_AW-1:0] out_base;
  logic              busy, finished, timeout_err, pp_en, pp_ack, wr_en, pp_done;
  logic [ADDR_W-1:0] pp_base_addrA, pp_base_addrB;
  logic [DATA_W-1:0] pp_out_pix, wr_data;
  logic [OUT_AW-1:0] wr_addr;

  pixel_result_collector #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_AW(OUT_AW), .CNT_W(CNT_W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_a(base_a), .base_b(base_b),
    .stride_a(stride_a), .num_pix(num_pix), .out_base(out_base), .busy(busy),
    .finished(finished), .timeout_err(timeout_err), .pp_en(pp_en),
    .pp_base_addrA(pp_base_addrA), .pp_base_addrB(pp_base_addrB),
    .pp_out_pix(pp_out_pix), .pp_done(pp_done), .pp_ack(pp_ack), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // responder model controls and observations
  int  lat_min = 0, lat_max = 4, hold_min = 0, hold_max = 2;
  bit  model_mute = 1'b0;
  bit  force_pix_en = 1'b0;
  logic [DATA_W-1:0] force_pix = '0;
  int  mdl_st = 0;
  logic [DATA_W-1:0]          pix_q[$];
  logic [2*ADDR_W-1:0]        addr_q[$];
  logic [OUT_AW+DATA_W-1:0]   got_q[$];
  logic [OUT_AW+DATA_W-1:0]   exp_q[$];
  int  fin_cnt = 0, overlap_cnt = 0, ack_err_cnt = 0, en_seen = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pixel processor: accept a request, answer after a latency, keep done high
  // for a chosen number of cycles after the acknowledge, then release.
  initial begin : proc_model
    int lc, hc;
    lc = 0;
    hc = 0;
    pp_done = 1'b0;
    pp_out_pix = '0;
    forever begin
      tick();
      if (!rst_n) begin
        mdl_st  = 0;
        pp_done = 1'b0;
      end else begin
        case (mdl_st)
          0: if (pp_en && !model_mute) begin
               addr_q.push_back({pp_base_addrB, pp_base_addrA});
               lc = $urandom_range(lat_max, lat_min);
               mdl_st = 1;
             end
          1: if (lc == 0) begin
               pp_out_pix = force_pix_en ? force_pix : DATA_W'($urandom);
               pix_q.push_back(pp_out_pix);
               pp_done = 1'b1;
               mdl_st = 2;
             end else lc--;
          2: if (pp_ack) begin
               hc = $urandom_range(hold_max, hold_min);
               mdl_st = 3;
             end
          default: if (hc == 0) begin
               pp_done = 1'b0;
               mdl_st = 0;
             end else hc--;
        endcase
      end
    end
  end

  // output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (finished) fin_cnt++;
    if (pp_en && pp_ack) overlap_cnt++;
    if (mdl_st == 3 && pp_done && !pp_ack) ack_err_cnt++;
    if (pp_en) en_seen++;
  end

  task automatic clear_obs();
    pix_q.delete(); addr_q.delete(); got_q.delete(); exp_q.delete();
    fin_cnt = 0; overlap_cnt = 0; ack_err_cnt = 0; en_seen = 0;
  endtask

  task automatic run_job(input int ba, input int bb, input int sa, input int n, input int ob,
                         input bit busy_poke, input string tag);
    int cnt;
    clear_obs();
    base_a = ADDR_W'(ba); base_b = ADDR_W'(bb); stride_a = ADDR_W'(sa);
    num_pix = CNT_W'(n); out_base = OUT_AW'(ob);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_en_first"}, pp_en, 1);
    if (busy_poke) begin
      tick();
      base_a = ADDR_W'($urandom); num_pix = CNT_W'(7); out_base = OUT_AW'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    cnt = 0;
    while (fin_cnt == 0 && cnt < 3000) begin
      tick();
      cnt++;
    end
    check({tag, "_fin_seen"}, (fin_cnt != 0), 1);
    tick();
    tick();
    check({tag, "_fin_once"}, fin_cnt, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_tmo_clear"}, timeout_err, 0);
    for (int i = 0; i < n; i++)
      exp_q.push_back({OUT_AW'((ob + i) % (1 << OUT_AW)), pix_q[i]});
    check({tag, "_nwrites"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_nreq"}, addr_q.size(), n);
    for (int i = 0; i < n && i < addr_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), addr_q[i],
            {ADDR_W'(bb), ADDR_W'((ba + i * sa) % (1 << ADDR_W))});
    check({tag, "_en_ack_overlap"}, overlap_cnt, 0);
    check({tag, "_ack_early_drop"}, ack_err_cnt, 0);
  endtask

  initial begin : main
    int cnt, snap;
    rst_n = 1'b0; start = 1'b0;
    base_a = '0; base_b = '0; stride_a = '0; num_pix = '0; out_base = '0;
    repeat (3) tick();
    check("reset_ctl", {busy, finished, timeout_err, pp_en, pp_ack, wr_en, wr_addr,
                        pp_base_addrA, pp_base_addrB}, 0);
    check("reset_data", wr_data, 0);
    rst_n = 1'b1;
    tick();

    // single pixel with fixed latency and data
    lat_min = 10; lat_max = 10; hold_min = 0; hold_max = 0;
    force_pix_en = 1'b1; force_pix = 32'h0000_1234;
    run_job(0, 6912, 0, 1, 0, 1'b0, "single");
    check("single_data", got_q[0], {12'd0, 32'h0000_1234});
    force_pix_en = 1'b0;

    // four pixels, stride 27
    lat_min = 0; lat_max = 6; hold_min = 0; hold_max = 2;
    run_job(0, 6912, 27, 4, 0, 1'b0, "four");
    check("four_last_addr", addr_q[3], {14'd6912, 14'd81});

    // address wrap on both the window and the write address
    run_job(16380, 5, 8, 2, 4095, 1'b0, "wrap");
    check("wrap_a1", addr_q[1][ADDR_W-1:0], 4);
    check("wrap_w1", got_q[1][OUT_AW+DATA_W-1:DATA_W], 0);

    // done held high 5 cycles past the acknowledge
    hold_min = 5; hold_max = 5;
    run_job(100, 200, 3, 1, 50, 1'b0, "stress");
    hold_min = 0; hold_max = 2;

    // start while busy is dropped
    run_job(1000, 77, 9, 3, 300, 1'b1, "poke");

    // randomized jobs
    for (int j = 0; j < 5; j++) begin
      lat_max = $urandom_range(8, 0);
      hold_max = $urandom_range(3, 0);
      run_job($urandom_range(16383, 0), $urandom_range(16383, 0), $urandom_range(16383, 0),
              $urandom_range(6, 1), $urandom_range(4095, 0), 1'b0, $sformatf("rnd%0d", j));
    end

    // watchdog: processor never answers
    clear_obs();
    model_mute = 1'b1;
    base_a = 14'd10; stride_a = 14'd1; num_pix = 12'd3; out_base = 12'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tmo_en", pp_en, 1);
    cnt = 0;
    while (finished !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("tmo_fin_delay", cnt, TO + 1);
    check("tmo_err", timeout_err, 1);
    check("tmo_en_low", pp_en, 0);
    tick();
    tick();
    check("tmo_no_write", got_q.size(), 0);
    check("tmo_fin_once", fin_cnt, 1);
    model_mute = 1'b0;

    // zero-pixel job; the accepted start also clears the sticky timeout flag
    clear_obs();
    num_pix = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_fin_e1", finished, 0);
    check("zero_tmo_cleared", timeout_err, 0);
    tick();
    check("zero_fin_e2", finished, 1);
    tick();
    check("zero_fin_pulse", finished, 0);
    check("zero_no_en", en_seen, 0);
    check("zero_busy_low", busy, 0);

    // reset during the acknowledge phase
    clear_obs();
    lat_min = 2; lat_max = 2; hold_min = 8; hold_max = 8;
    base_a = 14'd100; stride_a = 14'd3; num_pix = 12'd2; out_base = 12'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (pp_ack !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("rst_reach_ack", pp_ack, 1);
    rst_n = 1'b0;
    tick();
    check("rst_ctl", {busy, finished, timeout_err, pp_en, pp_ack, wr_en, wr_addr,
                      pp_base_addrA, pp_base_addrB}, 0);
    check("rst_data", wr_data, 0);
    snap = got_q.size();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("rst_no_write", got_q.size(), snap);
    check("rst_no_fin", fin_cnt, 0);
    check("rst_busy_low", busy, 0);
    check("rst_en_low", pp_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_result_collector.md
# pixel_result_collector

Initiator-side sequencer for the pixel point processor. It issues one pixel job at a time by driving the processor's enable and 14-bit base addresses, waits for `done`, captures the 32-bit `out_pix`, acknowledges the result, and writes it to the output feature-map memory at consecutive addresses. It sits between the layer controller (`start`/`finished`) and one `pixelpointprocessor` instance.

## Interface
- `ADDR_W`, 14: width of the processor base addresses.
- `DATA_W`, 32: width of the pixel result.
- `OUT_AW`, 12: output memory address width.
- `CNT_W`, 12: width of the pixel count.
- `TIMEOUT`, 1023: maximum cycles to wait for `pp_done` in REQ; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle job request; ignored while `busy`=1.
- `base_a`  in  ADDR_W  first input-window address.
- `base_b`  in  ADDR_W  kernel address, constant for the whole job.
- `stride_a`  in  ADDR_W  increment of the window address per pixel.
- `num_pix`  in  CNT_W  number of pixels to compute.
- `out_base`  in  OUT_AW  first output memory address.
- `busy`  out  1  high from the cycle after an accepted `start` until `finished`.
- `finished`  out  1  one-cycle pulse at job end.
- `timeout_err`  out  1  sticky; cleared only by the next accepted `start` or by reset.
- `pp_en`  out  1  processor enable.
- `pp_base_addrA`  out  ADDR_W  current window address.
- `pp_base_addrB`  out  ADDR_W  kernel address.
- `pp_out_pix`  in  DATA_W  processor result.
- `pp_done`  in  1  result valid.
- `pp_ack`  out  1  result acknowledge.
- `wr_en`  out  1  output memory write strobe, one cycle.
- `wr_addr`  out  OUT_AW  write address.
- `wr_data`  out  DATA_W  write data.

## Operation
- All outputs are registered. Reset drives every output to 0 and the state to IDLE.
- **IDLE**
  - When `start`=1, latch `base_a`, `base_b`, `stride_a`, `num_pix` and `out_base`.
  - Clear the pixel counter and `timeout_err`.
  - If `num_pix`=0, go to FIN. Otherwise go to REQ.
- **REQ**
  - `pp_en`=1. `pp_base_addrA` = current window address; `pp_base_addrB` = latched kernel address.
  - When `pp_done`=1: capture `pp_out_pix` into `wr_data`, pulse `wr_en`, drive `pp_en`=0 and `pp_ack`=1, then go to ACK.
  - If the watchdog reaches TIMEOUT cycles, set `timeout_err`, drive `pp_en`=0, and go to FIN with no write.
- **ACK** (4-phase handshake)
  - Hold `pp_ack`=1 until `pp_done`=0.
  - On that cycle: drop `pp_ack`, increment the counter, add `stride_a` to the window address, and increment `wr_addr`.
  - If the new counter equals `num_pix`, go to FIN. Otherwise go to REQ.
- **FIN**
  - `finished`=1 for one cycle, `busy`=0, then return to IDLE.
- Arithmetic:
  - Window address wraps modulo 2^ADDR_W.
  - `wr_addr` wraps modulo 2^OUT_AW.
  - The counter is compared with `num_pix` at full CNT_W width.
- `pp_done` sampled high in IDLE or FIN is ignored.
- A `start` that arrives while busy is dropped and is not queued.
- Reset asserted mid-job aborts on the next edge. All outputs become 0, no partial write completes, and no `finished` pulse is issued.

## Timing
- `start` is sampled at edge 0. At edge 1, `busy`=1 and `pp_en`=1 with valid addresses.
- `pp_done` is first seen high at edge k. At edge k+1:
  - `pp_en`=0, `pp_ack`=1, `wr_en`=1.
  - `wr_data` = the `pp_out_pix` value sampled at edge k.
  - `wr_addr` = `out_base` + pixel index.
- `pp_done` is seen low at edge m. At edge m+1, `pp_ack`=0, and then either `pp_en`=1 for the next pixel or `finished`=1.
- Minimum per-pixel overhead is 2 cycles beyond the processor latency.
- The watchdog counts REQ cycles with `pp_done`=0 and restarts at each REQ entry.

## Test plan
- **Single pixel.** Stimulus: `num_pix`=1, `base_a`=0, `base_b`=6912, `out_base`=0; model returns 0x0000_1234 after 10 cycles. Required response: one write {addr 0, data 0x1234}, `finished` exactly once, `busy` low afterwards.
- **Four pixels, stride 27.** Required response: `pp_base_addrA` sequence 0, 27, 54, 81; `pp_base_addrB` held at 6912; writes to 0..3 with the model's data in order.
- **Wrap.** Stimulus: `base_a`=16380, `stride_a`=8, 2 pixels; `out_base`=4095. Required response: addresses 16380 then 4; `wr_addr` 4095 then 0.
- **Handshake stress.** Stimulus: model holds `pp_done` high 5 cycles after `pp_ack` rises. Required response: `pp_ack` held high for those cycles; `pp_en` stays low; no second write.
- **Timeout.** Stimulus: TIMEOUT=20, model never asserts `pp_done`. Required response: `timeout_err`=1 and `finished` pulse 21 cycles after REQ entry; no `wr_en`.
- **Edge cases.**
  - `num_pix`=0: `finished` at edge 2 with no `pp_en`.
  - Reset during ACK: all outputs 0 next edge.
  - `start` while busy: ignored.
